// File: rtl/key_debounce.sv
// Seven independent button debouncers producing a level plus one-cycle press/release pulses.
// Defining KEY_REPEAT_EN adds auto-repeat press pulses while a key stays held.
module key_debounce #(
   parameter int DB_CYCLES     = 500000,
   parameter int REPEAT_DELAY  = 25000000,
   parameter int REPEAT_PERIOD = 5000000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [6:0] keys_raw,
   output logic [6:0] keys_level,
   output logic [6:0] keys_press,
   output logic [6:0] keys_release,
   output logic       key_any
);

   localparam int MAX_AB  = (DB_CYCLES > REPEAT_DELAY) ? DB_CYCLES : REPEAT_DELAY;
   localparam int MAX_CYC = (MAX_AB > REPEAT_PERIOD) ? MAX_AB : REPEAT_PERIOD;
   localparam int CW      = $clog2(MAX_CYC + 1);

   localparam logic [CW-1:0] CNT_ZERO = '0;
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [CW-1:0] CNT_MAX  = '1;
   localparam logic [CW-1:0] DB_LAST  = CW'(DB_CYCLES - 1);
   localparam bit            DB_ONE   = (DB_CYCLES <= 1);

   typedef enum logic [1:0] {
      UP      = 2'd0,
      DN_WAIT = 2'd1,
      DOWN    = 2'd2,
      UP_WAIT = 2'd3
   } state_t;

   logic [6:0] press_fire;

   for (genvar i = 0; i < 7; i++) begin : g_key
      logic          sync1;
      logic          sync2;
      state_t        state;
      logic [CW-1:0] cnt;
      logic          db_done;
      logic          accept_press;
      logic          accept_release;
      logic          rpt_fire;
      logic          level_r;
      logic          press_r;
      logic          release_r;

      // Inverting ahead of the synchronizer makes the reset value (0) mean "not pressed",
      // so a key held through reset is seen as a fresh press two cycles later.
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
         end else begin
            sync1 <= ~keys_raw[i];
            sync2 <= sync1;
         end
      end

      assign db_done        = (cnt == DB_LAST);
      assign accept_press   = (state == DN_WAIT && sync2 && db_done) ||
                              (DB_ONE && state == UP && sync2);
      assign accept_release = (state == UP_WAIT && !sync2 && db_done) ||
                              (DB_ONE && state == DOWN && !sync2);

`ifdef KEY_REPEAT_EN
      logic [CW-1:0] rpt_cnt;
      logic          rpt_armed;

      localparam logic [CW-1:0] RD_LAST = CW'(REPEAT_DELAY - 1);
      localparam logic [CW-1:0] RP_LAST = CW'(REPEAT_PERIOD - 1);

      assign rpt_fire = (state == DOWN) && sync2 &&
                        (rpt_armed ? (rpt_cnt == RP_LAST) : (rpt_cnt == RD_LAST));

      // Holding time is measured only while stably DOWN; any exit restarts from the initial delay.
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            rpt_cnt   <= CNT_ZERO;
            rpt_armed <= 1'b0;
         end else if (state != DOWN || !sync2) begin
            rpt_cnt   <= CNT_ZERO;
            rpt_armed <= 1'b0;
         end else if (rpt_fire) begin
            rpt_cnt   <= CNT_ZERO;
            rpt_armed <= 1'b1;
         end else if (rpt_cnt != CNT_MAX) begin
            rpt_cnt   <= rpt_cnt + CNT_ONE;
         end
      end
`else
      assign rpt_fire = 1'b0;
`endif

      assign press_fire[i] = accept_press | rpt_fire;

      // Debounce FSM: a level change is accepted on the edge where the count of
      // consecutive differing samples reaches DB_CYCLES; pulses are registered alongside.
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            state     <= UP;
            cnt       <= CNT_ZERO;
            level_r   <= 1'b0;
            press_r   <= 1'b0;
            release_r <= 1'b0;
         end else begin
            press_r   <= press_fire[i];
            release_r <= accept_release;
            case (state)
               UP: begin
                  if (sync2) begin
                     if (DB_ONE) begin
                        state   <= DOWN;
                        level_r <= 1'b1;
                        cnt     <= CNT_ZERO;
                     end else begin
                        state <= DN_WAIT;
                        cnt   <= CNT_ONE;
                     end
                  end
               end
               DN_WAIT: begin
                  if (!sync2) begin
                     state <= UP;
                     cnt   <= CNT_ZERO;
                  end else if (db_done) begin
                     state   <= DOWN;
                     level_r <= 1'b1;
                     cnt     <= CNT_ZERO;
                  end else if (cnt != CNT_MAX) begin
                     cnt <= cnt + CNT_ONE;
                  end
               end
               DOWN: begin
                  if (!sync2) begin
                     if (DB_ONE) begin
                        state   <= UP;
                        level_r <= 1'b0;
                        cnt     <= CNT_ZERO;
                     end else begin
                        state <= UP_WAIT;
                        cnt   <= CNT_ONE;
                     end
                  end
               end
               UP_WAIT: begin
                  if (sync2) begin
                     state <= DOWN;
                     cnt   <= CNT_ZERO;
                  end else if (db_done) begin
                     state   <= UP;
                     level_r <= 1'b0;
                     cnt     <= CNT_ZERO;
                  end else if (cnt != CNT_MAX) begin
                     cnt <= cnt + CNT_ONE;
                  end
               end
               default: begin
                  state   <= UP;
                  level_r <= 1'b0;
                  cnt     <= CNT_ZERO;
               end
            endcase
         end
      end

      assign keys_level[i]   = level_r;
      assign keys_press[i]   = press_r;
      assign keys_release[i] = release_r;
   end

   // Registered from the same per-key conditions so it lines up with keys_press exactly.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         key_any <= 1'b0;
      end else begin
         key_any <= |press_fire;
      end
   end

endmodule

// File: tb/tb_key_debounce.sv
// Scoreboard bench for key_debounce with DB_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8.
// Expectations depend on whether KEY_REPEAT_EN is defined for the build.
module tb_key_debounce;

   localparam int DB  = 4;
   localparam int RD  = 20;
   localparam int RP  = 8;
   localparam int LAT = DB + 2;

   typedef struct packed {
      int         cyc;
      logic [6:0] press;
      logic [6:0] rel;
      logic [6:0] level;
      logic       any;
   } ev_t;

   logic       clk = 1'b0;
   logic       rst;
   logic [6:0] keys_raw;
   logic [6:0] keys_level;
   logic [6:0] keys_press;
   logic [6:0] keys_release;
   logic       key_any;

   int  cyc = 0;
   int  compared = 0;
   int  mismatched = 0;
   ev_t exp_q[$];
   ev_t obs_q[$];

   key_debounce #(
      .DB_CYCLES    (DB),
      .REPEAT_DELAY (RD),
      .REPEAT_PERIOD(RP)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .keys_raw    (keys_raw),
      .keys_level  (keys_level),
      .keys_press  (keys_press),
      .keys_release(keys_release),
      .key_any     (key_any)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Any nonzero pulse output is an observed event for the scoreboard.
   always @(negedge clk) begin
      if (rst === 1'b0 && (keys_press !== 7'd0 || keys_release !== 7'd0 || key_any !== 1'b0))
         obs_q.push_back('{cyc, keys_press, keys_release, keys_level, key_any});
   end

   function automatic void push_exp(input int c, input logic [6:0] p, input logic [6:0] r,
                                    input logic [6:0] l, input logic a);
      exp_q.push_back('{c, p, r, l, a});
   endfunction

   task automatic test_reset;
      rst      = 1'b1;
      keys_raw = 7'h7F;
      exp_q.delete();
      obs_q.delete();
      repeat (3) @(negedge clk);
      compared++;
      if (keys_level !== 7'd0) begin
         mismatched++;
         $display("[TB] FAIL reset_level: got %b want 0000000", keys_level);
      end
      compared++;
      if (keys_press !== 7'd0) begin
         mismatched++;
         $display("[TB] FAIL reset_press: got %b want 0000000", keys_press);
      end
      compared++;
      if (keys_release !== 7'd0) begin
         mismatched++;
         $display("[TB] FAIL reset_release: got %b want 0000000", keys_release);
      end
      compared++;
      if (key_any !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL reset_any: got %b want 0", key_any);
      end
      rst = 1'b0;
      repeat (6) @(negedge clk);
      compared++;
      if (keys_level !== 7'd0 || obs_q.size() != 0) begin
         mismatched++;
         $display("[TB] FAIL idle_after_reset: got level=%b events=%0d want level=0000000 events=0",
                  keys_level, obs_q.size());
         obs_q.delete();
      end
   endtask

   task automatic test_single_press;
      int  c;
      ev_t e, o;
      @(negedge clk);
      c = cyc;
      keys_raw[0] = 1'b0;
      push_exp(c + LAT, 7'h01, 7'h00, 7'h01, 1'b1);
      repeat (LAT - 1) @(negedge clk);
      compared++;
      if (keys_level[0] !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL single_early_level: got %b want 0 at cycle %0d", keys_level[0], cyc);
      end
      @(negedge clk);
      compared++;
      if (keys_level[0] !== 1'b1) begin
         mismatched++;
         $display("[TB] FAIL single_level: got %b want 1 at cycle %0d", keys_level[0], cyc);
      end
      keys_raw[0] = 1'b1;
      push_exp(c + 2 * LAT, 7'h00, 7'h01, 7'h00, 1'b0);
      repeat (LAT + 4) @(negedge clk);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         compared++;
         if (obs_q.size() == 0) begin
            mismatched++;
            $display("[TB] FAIL single_event: got none want cyc=%0d press=%b rel=%b level=%b any=%b",
                     e.cyc, e.press, e.rel, e.level, e.any);
         end else begin
            o = obs_q.pop_front();
            if (o !== e) begin
               mismatched++;
               $display("[TB] FAIL single_event: got cyc=%0d press=%b rel=%b level=%b any=%b want cyc=%0d press=%b rel=%b level=%b any=%b",
                        o.cyc, o.press, o.rel, o.level, o.any, e.cyc, e.press, e.rel, e.level, e.any);
            end
         end
      end
      compared++;
      if (obs_q.size() != 0) begin
         mismatched++;
         $display("[TB] FAIL single_extra: got %0d extra events want 0", obs_q.size());
         obs_q.delete();
      end
   endtask

   task automatic test_glitch;
      @(negedge clk);
      keys_raw[1] = 1'b0;
      repeat (3) @(negedge clk);
      keys_raw[1] = 1'b1;
      repeat (10) @(negedge clk);
      compared++;
      if (keys_level !== 7'd0) begin
         mismatched++;
         $display("[TB] FAIL glitch_level: got %b want 0000000", keys_level);
      end
      compared++;
      if (obs_q.size() != 0) begin
         mismatched++;
         $display("[TB] FAIL glitch_pulses: got %0d events want 0", obs_q.size());
         obs_q.delete();
      end
   endtask

   task automatic test_simultaneous;
      int  c;
      ev_t e, o;
      @(negedge clk);
      c = cyc;
      keys_raw = 7'b0111110;
      push_exp(c + LAT, 7'b1000001, 7'h00, 7'b1000001, 1'b1);
      repeat (LAT) @(negedge clk);
      keys_raw = 7'h7F;
      push_exp(c + 2 * LAT, 7'h00, 7'b1000001, 7'h00, 1'b0);
      repeat (LAT + 4) @(negedge clk);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         compared++;
         if (obs_q.size() == 0) begin
            mismatched++;
            $display("[TB] FAIL simultaneous_event: got none want cyc=%0d press=%b rel=%b level=%b any=%b",
                     e.cyc, e.press, e.rel, e.level, e.any);
         end else begin
            o = obs_q.pop_front();
            if (o !== e) begin
               mismatched++;
               $display("[TB] FAIL simultaneous_event: got cyc=%0d press=%b rel=%b level=%b any=%b want cyc=%0d press=%b rel=%b level=%b any=%b",
                        o.cyc, o.press, o.rel, o.level, o.any, e.cyc, e.press, e.rel, e.level, e.any);
            end
         end
      end
      compared++;
      if (obs_q.size() != 0) begin
         mismatched++;
         $display("[TB] FAIL simultaneous_extra: got %0d extra events want 0", obs_q.size());
         obs_q.delete();
      end
   endtask

   task automatic test_back_to_back;
      int  c;
      ev_t e, o;
      @(negedge clk);
      c = cyc;
      keys_raw[3] = 1'b0;
      @(negedge clk);
      keys_raw[4] = 1'b0;
      push_exp(c + LAT,     7'b0001000, 7'h00, 7'b0001000, 1'b1);
      push_exp(c + LAT + 1, 7'b0010000, 7'h00, 7'b0011000, 1'b1);
      repeat (LAT) @(negedge clk);
      keys_raw = 7'h7F;
      push_exp(c + 2 * LAT + 1, 7'h00, 7'b0011000, 7'h00, 1'b0);
      repeat (LAT + 4) @(negedge clk);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         compared++;
         if (obs_q.size() == 0) begin
            mismatched++;
            $display("[TB] FAIL back_to_back_event: got none want cyc=%0d press=%b rel=%b level=%b any=%b",
                     e.cyc, e.press, e.rel, e.level, e.any);
         end else begin
            o = obs_q.pop_front();
            if (o !== e) begin
               mismatched++;
               $display("[TB] FAIL back_to_back_event: got cyc=%0d press=%b rel=%b level=%b any=%b want cyc=%0d press=%b rel=%b level=%b any=%b",
                        o.cyc, o.press, o.rel, o.level, o.any, e.cyc, e.press, e.rel, e.level, e.any);
            end
         end
      end
      compared++;
      if (obs_q.size() != 0) begin
         mismatched++;
         $display("[TB] FAIL back_to_back_extra: got %0d extra events want 0", obs_q.size());
         obs_q.delete();
      end
   endtask

   task automatic test_reset_held;
      int  c, r;
      ev_t e, o;
      @(negedge clk);
      c = cyc;
      keys_raw[0] = 1'b0;
      push_exp(c + LAT, 7'h01, 7'h00, 7'h01, 1'b1);
      repeat (LAT + 2) @(negedge clk);
      rst = 1'b1;
      #1;
      compared++;
      if (keys_level !== 7'd0 || keys_press !== 7'd0 || keys_release !== 7'd0 || key_any !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL reset_held_clear: got level=%b press=%b rel=%b any=%b want all 0",
                  keys_level, keys_press, keys_release, key_any);
      end
      @(negedge clk);
      compared++;
      if (keys_level !== 7'd0) begin
         mismatched++;
         $display("[TB] FAIL reset_held_level: got %b want 0000000", keys_level);
      end
      rst = 1'b0;
      r = cyc;
      push_exp(r + LAT, 7'h01, 7'h00, 7'h01, 1'b1);
      repeat (LAT) @(negedge clk);
      keys_raw[0] = 1'b1;
      push_exp(r + 2 * LAT, 7'h00, 7'h01, 7'h00, 1'b0);
      repeat (LAT + 4) @(negedge clk);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         compared++;
         if (obs_q.size() == 0) begin
            mismatched++;
            $display("[TB] FAIL reset_held_event: got none want cyc=%0d press=%b rel=%b level=%b any=%b",
                     e.cyc, e.press, e.rel, e.level, e.any);
         end else begin
            o = obs_q.pop_front();
            if (o !== e) begin
               mismatched++;
               $display("[TB] FAIL reset_held_event: got cyc=%0d press=%b rel=%b level=%b any=%b want cyc=%0d press=%b rel=%b level=%b any=%b",
                        o.cyc, o.press, o.rel, o.level, o.any, e.cyc, e.press, e.rel, e.level, e.any);
            end
         end
      end
      compared++;
      if (obs_q.size() != 0) begin
         mismatched++;
         $display("[TB] FAIL reset_held_extra: got %0d extra events want 0", obs_q.size());
         obs_q.delete();
      end
   endtask

   task automatic test_reset_mid_debounce;
      @(negedge clk);
      keys_raw[2] = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      keys_raw[2] = 1'b1;
      rst = 1'b0;
      repeat (12) @(negedge clk);
      compared++;
      if (keys_level !== 7'd0 || obs_q.size() != 0) begin
         mismatched++;
         $display("[TB] FAIL reset_mid_debounce: got level=%b events=%0d want level=0000000 events=0",
                  keys_level, obs_q.size());
         obs_q.delete();
      end
   endtask

   task automatic test_repeat;
      int  c, a;
      ev_t e, o;
      @(negedge clk);
      c = cyc;
      a = c + LAT;
      keys_raw[5] = 1'b0;
      push_exp(a, 7'b0100000, 7'h00, 7'b0100000, 1'b1);
`ifdef KEY_REPEAT_EN
      for (int t = RD; t < 57; t += RP)
         push_exp(a + t, 7'b0100000, 7'h00, 7'b0100000, 1'b1);
`endif
      repeat (LAT + 56) @(negedge clk);
      keys_raw[5] = 1'b1;
      push_exp(a + 56 + LAT, 7'h00, 7'b0100000, 7'h00, 1'b0);
      repeat (LAT + 4) @(negedge clk);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         compared++;
         if (obs_q.size() == 0) begin
            mismatched++;
            $display("[TB] FAIL repeat_event: got none want cyc=%0d press=%b rel=%b level=%b any=%b",
                     e.cyc, e.press, e.rel, e.level, e.any);
         end else begin
            o = obs_q.pop_front();
            if (o !== e) begin
               mismatched++;
               $display("[TB] FAIL repeat_event: got cyc=%0d press=%b rel=%b level=%b any=%b want cyc=%0d press=%b rel=%b level=%b any=%b",
                        o.cyc, o.press, o.rel, o.level, o.any, e.cyc, e.press, e.rel, e.level, e.any);
            end
         end
      end
      compared++;
      if (obs_q.size() != 0) begin
         mismatched++;
         $display("[TB] FAIL repeat_extra: got %0d extra events want 0", obs_q.size());
         obs_q.delete();
      end
   endtask

   initial begin
      test_reset();
      test_single_press();
      test_glitch();
      test_simultaneous();
      test_back_to_back();
      test_reset_held();
      test_reset_mid_debounce();
      test_repeat();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
